// File: rtl/fpu_sqrt_sched_if.sv
// fpu_sqrt_sched_if: requester and response handshakes of the shared sqrt scheduler
// master: drives req*_valid/x/tag and resp_ready; slave: drives req*_ready and resp_*
interface fpu_sqrt_sched_if #(parameter int TAGW = 4);
  logic            req0_valid;
  logic            req0_ready;
  logic [31:0]     req0_x;
  logic [TAGW-1:0] req0_tag;
  logic            req1_valid;
  logic            req1_ready;
  logic [31:0]     req1_x;
  logic [TAGW-1:0] req1_tag;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_y;
  logic [TAGW-1:0] resp_tag;
  logic            resp_src;
  modport master (
    output req0_valid, req0_x, req0_tag, req1_valid, req1_x, req1_tag, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_y, resp_tag, resp_src
  );
  modport slave (
    input  req0_valid, req0_x, req0_tag, req1_valid, req1_x, req1_tag, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_y, resp_tag, resp_src
  );
endinterface

// File: rtl/fpu_sqrt_sched.sv
// fpu_sqrt_sched: round-robin sharing of a fixed-latency sqrt unit with in-order credit-gated response FIFO
// clk/rstn: clock, sync active-low reset; i_flush: drop in-flight and buffered ops
// o_sq_x/i_sq_y: sqrt unit operand/result; o_busy: anything in flight or buffered
// bus: two requester handshakes and the show-ahead response handshake
module fpu_sqrt_sched #(
  parameter int LAT   = 5,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_flush,
  output logic [31:0] o_sq_x,
  input  logic [31:0] i_sq_y,
  output logic        o_busy,
  fpu_sqrt_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1);
  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            src;
  } ent_t;
  logic            r_last;
  logic [LAT-1:0]  r_v;
  logic [LAT-1:0]  r_src;
  logic [TAGW-1:0] r_tag [LAT];
  logic [CW-1:0]   r_icnt;
  logic [CW-1:0]   r_fcnt;
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  ent_t            r_mem [DEPTH];
  logic            w_ok;
  logic            w_sel;
  logic            w_acc;
  logic            w_cap;
  logic            w_pop;
  logic [TAGW-1:0] w_tag;
  // credit counts the buffered and in-flight results from registered state only
  always_comb begin
    w_ok  = (r_icnt + r_fcnt) < CW'(DEPTH);
    w_sel = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_acc = (bus.req0_valid | bus.req1_valid) & w_ok & ~i_flush;
    w_tag = w_sel ? bus.req1_tag : bus.req0_tag;
    w_cap = r_v[LAT-1];
    w_pop = (r_fcnt != '0) & bus.resp_ready;
    bus.req0_ready = w_ok & ~i_flush & bus.req0_valid & ~w_sel;
    bus.req1_ready = w_ok & ~i_flush & bus.req1_valid & w_sel;
    o_sq_x = w_acc ? (w_sel ? bus.req1_x : bus.req0_x) : '0;
    bus.resp_valid = r_fcnt != '0;
    {bus.resp_y, bus.resp_tag, bus.resp_src} = r_mem[r_rp];
    o_busy = (r_icnt != '0) | (r_fcnt != '0);
  end
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_v    <= '0;
      r_icnt <= '0;
      r_fcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      r_v    <= {r_v[LAT-2:0], w_acc};
      r_icnt <= r_icnt + CW'(w_acc) - CW'(w_cap);
      r_fcnt <= r_fcnt + CW'(w_cap) - CW'(w_pop);
      if (w_cap) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
    end
    // r_last=1 gives requester 0 priority on the next contended cycle
    if (!rstn) r_last <= 1'b1;
    else if (w_acc) r_last <= w_sel;
  end
  // payload paths need no reset: only the valid bits and pointers qualify them
  always_ff @(posedge clk) begin
    r_tag[0] <= w_tag;
    for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    r_src <= {r_src[LAT-2:0], w_sel};
    if (w_cap) r_mem[r_wp] <= {i_sq_y, r_tag[LAT-1], r_src[LAT-1]};
  end
endmodule

// File: tb/tb_fpu_sqrt_sched.sv
// tb_fpu_sqrt_sched: directed checks of arbitration, credit, flush and reset for fpu_sqrt_sched
module tb_fpu_sqrt_sched;
  localparam int LAT = 5, DEPTH = 4, TAGW = 4;
  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            src;
  } exp_t;
  logic        clk = 0;
  logic        rstn = 0;
  logic        flush = 0;
  logic [31:0] sq_x;
  logic [31:0] sq_y;
  logic        busy;
  logic [31:0] pipe [LAT];
  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          acc, i0, i1;
  bit          seen;
  logic [31:0] t3_x [6] = '{32'h3f800000, 32'h40800000, 32'h41100000, 32'h41800000, 32'h41c80000, 32'h42800000};
  logic [31:0] t4a [2] = '{32'h41100000, 32'h42c80000};
  logic [31:0] t4b [2] = '{32'h41800000, 32'h42800000};
  always #5 clk = ~clk;
  fpu_sqrt_sched_if #(.TAGW(TAGW)) bus ();
  fpu_sqrt_sched #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn), .i_flush(flush), .o_sq_x(sq_x), .i_sq_y(sq_y), .o_busy(busy), .bus(bus)
  );
  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    case (x)
      32'h00000000: return 32'h00000000;
      32'h3f800000: return 32'h3f800000;
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      32'h41c80000: return 32'h40a00000;
      32'h42800000: return 32'h41000000;
      32'h42c80000: return 32'h41200000;
      default:      return 32'hffc00000;
    endcase
  endfunction
  always @(posedge clk) begin
    pipe[0] <= sqrt_ref(sq_x);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sq_y = pipe[LAT-1];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rstn || flush) q.delete();
    else begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) chk("stray_resp", bus.resp_valid, 0);
        else begin
          e = q.pop_front();
          chk("sb_y", bus.resp_y, e.y);
          chk("sb_tag", bus.resp_tag, e.tag);
          chk("sb_src", bus.resp_src, e.src);
        end
      end
      if (bus.req0_valid && bus.req0_ready) q.push_back({sqrt_ref(bus.req0_x), bus.req0_tag, 1'b0});
      if (bus.req1_valid && bus.req1_ready) q.push_back({sqrt_ref(bus.req1_x), bus.req1_tag, 1'b1});
      if (q.size() > DEPTH) chk("fifo_overflow", q.size(), DEPTH);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
  endtask
  task automatic drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      mid();
      done = !busy && !bus.resp_valid;
    end
    chk(tag, done, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    idle();
    bus.req0_x = 0; bus.req0_tag = 0; bus.req1_x = 0; bus.req1_tag = 0;
    bus.resp_ready = 1;
    repeat (2) tick();
    rstn = 1;
    mid();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_sq_x", sq_x, 0);
    tick();
    bus.req0_valid = 1; bus.req0_x = 32'h40800000; bus.req0_tag = 3;
    mid();
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_sq_x", sq_x, 32'h40800000);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) idle();
      mid();
      if (c == 1) begin
        chk("t1_busy", busy, 1);
        chk("t1_sq_x_idle", sq_x, 0);
      end
      if (c == 5) chk("t1_early", bus.resp_valid, 0);
      if (c == 6) begin
        chk("t1_valid", bus.resp_valid, 1);
        chk("t1_y", bus.resp_y, 32'h40000000);
        chk("t1_tag", bus.resp_tag, 3);
        chk("t1_src", bus.resp_src, 0);
      end
      if (c == 7) chk("t1_idle", busy, 0);
    end
    tick();
    bus.req1_valid = 1; bus.req1_x = 32'h00000000; bus.req1_tag = 1;
    mid();
    chk("t2_ready1", bus.req1_ready, 1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      idle();
      mid();
      if (bus.resp_valid) begin
        seen = 1;
        chk("t2_y", bus.resp_y, 0);
        chk("t2_src", bus.resp_src, 1);
        chk("t2_tag", bus.resp_tag, 1);
      end
    end
    chk("t2_seen", seen, 1);
    drain("t2_drain");
    bus.resp_ready = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.req0_valid = 1; bus.req0_x = t3_x[acc < 6 ? acc : 5]; bus.req0_tag = TAGW'(acc);
      mid();
      if (bus.req0_ready) acc++;
    end
    chk("t3_accepted", acc, 4);
    chk("t3_blocked", bus.req0_ready, 0);
    chk("t3_full_valid", bus.resp_valid, 1);
    tick();
    bus.resp_ready = 1;
    mid();
    chk("t3_pop_no_credit", bus.req0_ready, 0);
    chk("t3_pop_valid", bus.resp_valid, 1);
    tick();
    bus.resp_ready = 0;
    mid();
    chk("t3_credit_back", bus.req0_ready, 1);
    if (bus.req0_ready) acc++;
    tick();
    bus.req0_x = t3_x[5]; bus.req0_tag = 5;
    mid();
    chk("t3_one_more_only", bus.req0_ready, 0);
    chk("t3_total", acc, 5);
    tick();
    idle();
    bus.resp_ready = 1;
    mid();
    drain("t3_drain");
    tick();
    rstn = 0;
    mid();
    tick();
    rstn = 1;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      bus.req0_valid = 1; bus.req0_x = t4a[i0]; bus.req0_tag = TAGW'(8 + i0);
      bus.req1_valid = 1; bus.req1_x = t4b[i1]; bus.req1_tag = TAGW'(12 + i1);
      mid();
      chk("t4_grant0", bus.req0_ready, c % 2 == 0);
      chk("t4_grant1", bus.req1_ready, c % 2 == 1);
      if (bus.req0_ready) i0++;
      if (bus.req1_ready) i1++;
    end
    tick();
    idle();
    mid();
    drain("t4_drain");
    tick();
    bus.req0_valid = 1; bus.req0_x = 32'h3f800000; bus.req0_tag = 1;
    mid();
    chk("t5_issue0", bus.req0_ready, 1);
    tick();
    bus.req0_x = 32'h40800000; bus.req0_tag = 2;
    mid();
    chk("t5_issue1", bus.req0_ready, 1);
    tick();
    bus.req0_x = 32'h41100000; bus.req0_tag = 3;
    flush = 1;
    mid();
    chk("t5_flush_ready", bus.req0_ready, 0);
    chk("t5_flush_sq_x", sq_x, 0);
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (c == 3) begin
        flush = 0;
        idle();
      end
      if (c == 4) begin
        bus.req0_valid = 1; bus.req0_x = 32'h41c80000; bus.req0_tag = 4;
      end
      if (c == 5) idle();
      mid();
      if (c == 3 || c == 4) chk("t5_busy_clear", busy, 0);
      if (c == 4) chk("t5_reissue", bus.req0_ready, 1);
      if (c >= 3 && c <= 9) chk("t5_quiet", bus.resp_valid, 0);
      if (c == 10) begin
        chk("t5_valid", bus.resp_valid, 1);
        chk("t5_y", bus.resp_y, 32'h40a00000);
        chk("t5_tag", bus.resp_tag, 4);
      end
    end
    drain("t5_drain");
    bus.resp_ready = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 4) begin
        bus.req0_valid = 1; bus.req0_x = t3_x[c]; bus.req0_tag = TAGW'(c);
      end
      if (c == 4) idle();
      if (c == 7) rstn = 0;
      mid();
      if (c < 4) chk("t6_issue", bus.req0_ready, 1);
      if (c == 7) chk("t6_buffered", bus.resp_valid, 1);
    end
    tick();
    rstn = 1;
    bus.req0_valid = 1; bus.req0_x = 32'h40800000; bus.req0_tag = 9;
    bus.req1_valid = 1; bus.req1_x = 32'h41100000; bus.req1_tag = 10;
    mid();
    chk("t6_resp_valid", bus.resp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_first_g0", bus.req0_ready, 1);
    chk("t6_first_g1", bus.req1_ready, 0);
    tick();
    mid();
    chk("t6_second_g1", bus.req1_ready, 1);
    tick();
    idle();
    bus.resp_ready = 1;
    mid();
    drain("t6_drain");
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_sqrt_sched.md
Name: fpu_sqrt_sched

Overview:
- Shares the single pipelined FPU square-root unit between two requesters (e.g. two issue slots) via round-robin arbitration.
- The sqrt pipeline has fixed latency and no valid bits or stall. This block supplies both: it tracks in-flight operations with a valid/tag shift register.
- Results land in a response FIFO with valid/ready backpressure. Issue is credit-gated, so a result is never produced without a free FIFO slot.

Parameters:
LAT, 5, sqrt unit latency: operand driven on sq_x in cycle t gives its result on sq_y in cycle t+LAT.
DEPTH, 4, response FIFO entries (power of two, >=2).
TAGW, 4, width of requester-supplied tag.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operand
req0_ready  out  1  requester 0 accepted this cycle when valid&ready
req0_x  in  32  requester 0 operand (IEEE single)
req0_tag  in  TAGW  requester 0 tag
req1_valid  in  1  requester 1 has an operand
req1_ready  out  1  requester 1 accepted this cycle when valid&ready
req1_x  in  32  requester 1 operand
req1_tag  in  TAGW  requester 1 tag
flush  in  1  drop all in-flight ops and buffered results
sq_x  out  32  operand to sqrt unit
sq_y  in  32  result from sqrt unit
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_y  out  32  sqrt result
resp_tag  out  TAGW  tag of the originating request
resp_src  out  1  originating requester (0/1)
busy  out  1  any op in flight or buffered

Behaviour:
- Reset: rstn is synchronous and active-low on clk. It clears the in-flight shift register, the FIFO pointers and count, and sets the RR pointer so requester 0 has priority. After reset: resp_valid=0, busy=0, req*_ready=0 unless the credit rule admits.
- Credit rule: issue_ok = (fifo_count + inflight_count) < DEPTH.
  - fifo_count and inflight_count are the registered values of the current cycle.
  - A same-cycle pop does not return credit until the next cycle.
- Arbitration (combinational):
  - If only one req valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - req_ready = issue_ok & grant; the non-granted ready is 0.
  - The RR pointer updates only on an accepted handshake.
- Issue:
  - On accept, sq_x = selected req_x in that same cycle.
  - {1, tag, src} enters stage 0 of the LAT-deep in-flight shift register at the clock edge.
  - When no accept occurs, sq_x = 0 and a 0 valid bit enters the shift register.
- Capture:
  - The shift register's last stage corresponds to cycle t+LAT of an issue.
  - When that stage is valid, {sq_y, tag, src} is written into the FIFO at the end of that cycle.
  - The credit rule guarantees the FIFO is never full at write; the bench asserts this.
- Response:
  - FIFO is show-ahead; resp_* reflect the head entry. Pop on resp_valid & resp_ready.
  - A result issued in cycle t has resp_valid no earlier than cycle t+LAT+1.
  - Responses are returned strictly in issue order across both requesters.
  - Simultaneous push and pop when count=DEPTH-1 or count=1: count stays unchanged, pointers wrap modulo DEPTH.
- Flush (synchronous, has priority over all other updates that cycle):
  - Clears all in-flight valid bits, FIFO count and pointers.
  - No handshake is accepted in a flush cycle (req_ready forced 0). The RR pointer is unchanged.
  - resp_valid is 0 the next cycle. sq_y results from flushed ops are discarded.
- Reset mid-operation: same effect as flush plus RR pointer reset. No stale result may appear afterwards.
- busy = (inflight_count != 0) | (fifo_count != 0).
- inflight_count is a counter, not a popcount: +1 on accept, -1 on capture, both in the same cycle means unchanged. Range 0..LAT.

Test Plan:
- Single op: req0 x=0x40800000 tag=3 at cycle 0, resp_ready=1 -> sq_x=0x40800000 at cycle 0; resp_valid at cycle 6 with resp_y=0x40000000, tag=3, src=0; busy=0 at cycle 7.
- Zero operand: req1 x=0x00000000 tag=1 -> resp_y=0x00000000, src=1, tag=1.
- Credit backpressure: DEPTH=4, resp_ready=0, req0 valid continuously with 6 distinct ops -> exactly 4 accepted, then req0_ready=0. After one pop, exactly one more is accepted one cycle later. FIFO never overflows.
- Round robin: both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1. Responses arrive in the same src order with matching tags and correct roots (e.g. 9.0->3.0 = 0x40400000, 16.0->4.0 = 0x40800000).
- Flush: issue 3 ops, assert flush at cycle 2 -> no resp_valid ever for those ops. busy=0 from cycle 3. An op issued at cycle 4 returns normally at cycle 10.
- Reset mid-op: 2 ops in flight plus 2 buffered, rstn=0 for 1 cycle -> resp_valid=0, busy=0 afterwards. No stale responses appear. Next simultaneous request pair grants req0 first.
